and_tt_sequencer: RTL and testbench
===================================

// Module: and_tt_sequencer
// PURPOSE
//  Upstream stimulus/checker stage for the N-input AND port. On a start pulse it walks the
//  input vector x through 0..2^N_IN-1. For each vector it waits SETTLE_CYCLES, samples the
//  AND output z and compares it to the expected value (&x). It records a per-vector result
//  map and a mismatch count. Replaces hand-written #delay benches with a clocked self-check.
// PARAMETERS
//  N_IN           3  number of AND inputs driven; legal 1..4
//  SETTLE_CYCLES  4  cycles x is held before z is sampled; legal >=1
// PORTS
//  clk         in   1        single clock, rising edge
//  rst         in   1        asynchronous, active-high reset
//  start       in   1        request a sweep; sampled only in IDLE
//  z           in   1        AND output from the port under test
//  x           out  N_IN     drives the AND inputs, bit0 = X1
//  busy        out  1        high from start acceptance until DONE is left
//  done        out  1        one-cycle pulse at end of sweep
//  pass        out  1        1 = last sweep had zero mismatches; held until next start
//  result_map  out  2^N_IN   bit k = z sampled for vector k
//  fail_count  out  N_IN+1   mismatches in the last sweep, saturates at 2^N_IN
// BEHAVIOUR
//  Reset: state=IDLE; x=0; busy=0; done=0; pass=0; result_map=0; fail_count=0.
//  FSM states: IDLE, SETTLE, SAMPLE, DONE.
//  - IDLE, start=1 at edge: x<=0, cnt<=SETTLE_CYCLES-1, result_map<=0, fail_count<=0,
//    pass<=0, busy<=1; go to SETTLE.
//  - SETTLE: if cnt==0 go to SAMPLE, else cnt<=cnt-1. Lasts exactly SETTLE_CYCLES cycles.
//  - SAMPLE (1 cycle): result_map[x]<=z. If z!=(&x), fail_count<=fail_count+1.
//    If x==2^N_IN-1, go to DONE. Else x<=x+1, cnt reloads, go to SETTLE.
//  - DONE (1 cycle): done=1, pass=(fail_count==0), busy=1; then IDLE with busy<=0.
//  Latency: done high in cycle 2^N_IN*(SETTLE_CYCLES+1) after the start-accepting edge.
//    Defaults: cycle 40.
//  x holds the last vector (all ones) after the sweep, until the next start or reset.
//  start while busy is ignored; no queuing. start held high in IDLE restarts on the
//    cycle after DONE.
//  z is sampled only in SAMPLE; z changes during SETTLE have no effect.
//  rst asserted mid-sweep: all outputs return to reset values immediately. No done pulse.
//  Vector index wrap: x never increments past 2^N_IN-1.
// CONFIGURATION
//  AND_TT_STOP_ON_FAIL_EN defined:
//    - The first SAMPLE with a mismatch goes straight to DONE, with fail_count=1 and pass=0.
//    - x holds the failing vector; result_map bits above it stay 0.
//  Not defined:
//    - The sweep always covers all 2^N_IN vectors; fail_count totals all mismatches.
// TESTING
//  1 Correct AND port, defaults, start pulse at cycle 0:
//    done at cycle 40, pass=1, result_map=8'h80, fail_count=0.
//  2 z tied 0 -> result_map=8'h00, fail_count=1, pass=0.
//    With STOP_ON_FAIL_EN: done at cycle 40, x=3'b111.
//  3 z tied 1 -> fail_count=7, result_map=8'hFF.
//    With STOP_ON_FAIL_EN: done at cycle 5, x=0, fail_count=1.
//  4 rst pulsed at cycle 17 of a sweep -> all outputs 0 next cycle; no done pulse.
//    Fresh start then completes normally (scenario 1 values).
//  5 start re-pulsed at cycles 3 and 20 of a sweep -> ignored; single done at cycle 40.
//  6 N_IN=2, SETTLE_CYCLES=1 -> done at cycle 8, result_map=4'h8.
//    z toggling during SETTLE does not change the result.

Source files
------------

// File: rtl/and_tt_sequencer.sv
// Clocked truth-table sweep for an N-input AND port: drives every vector on x, samples z, counts mismatches.
// Optional build macro AND_TT_STOP_ON_FAIL_EN ends the sweep at the first mismatching vector.
module and_tt_sequencer #(
  parameter int N_IN          = 3,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   z,
  output logic [N_IN-1:0]        x,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [(1<<N_IN)-1:0]   result_map,
  output logic [N_IN:0]          fail_count
);

  localparam int NV = 1 << N_IN;
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [CW-1:0]   CNT_LOAD = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]   CNT_ZERO = '0;
  localparam logic [N_IN-1:0] X_ONE    = N_IN'(1);
  localparam logic [N_IN-1:0] X_LAST   = '1;
  localparam logic [N_IN:0]   FC_ONE   = (N_IN+1)'(1);
  localparam logic [N_IN:0]   FC_MAX   = (N_IN+1)'(NV);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic            mismatch;
  logic            last_vec;
  logic            stop_now;
  logic [N_IN:0]   fail_inc;

  assign mismatch = (z != (&x));
  assign last_vec = (x == X_LAST);
  assign fail_inc = (fail_count == FC_MAX) ? fail_count : fail_count + FC_ONE;
  assign done     = (state == DONE);

`ifdef AND_TT_STOP_ON_FAIL_EN
  assign stop_now = mismatch;
`else
  assign stop_now = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SETTLE;
      SETTLE:  if (cnt == CNT_ZERO) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = (last_vec || stop_now) ? DONE : SETTLE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // pass is resolved on the SAMPLE->DONE edge so it is valid alongside the done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x          <= '0;
      cnt        <= '0;
      result_map <= '0;
      fail_count <= '0;
      pass       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            x          <= '0;
            cnt        <= CNT_LOAD;
            result_map <= '0;
            fail_count <= '0;
            pass       <= 1'b0;
            busy       <= 1'b1;
          end
        end
        SETTLE: begin
          if (cnt != CNT_ZERO) cnt <= cnt - CNT_ONE;
        end
        SAMPLE: begin
          result_map[x] <= z;
          if (mismatch) fail_count <= fail_inc;
          if (last_vec || stop_now) begin
            pass <= !mismatch && (fail_count == '0);
          end else begin
            x   <= x + X_ONE;
            cnt <= CNT_LOAD;
          end
        end
        DONE: begin
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_and_tt_sequencer.sv
// Scoreboard bench for and_tt_sequencer: a default instance and an N_IN=2, SETTLE_CYCLES=1 instance.
module tb_and_tt_sequencer;

  logic       clk = 1'b0;
  logic       rst;

  logic       start;
  logic       z;
  logic [2:0] x;
  logic       busy, done, pass;
  logic [7:0] result_map;
  logic [3:0] fail_count;

  logic       start2;
  logic       z2;
  logic [1:0] x2;
  logic       busy2, done2, pass2;
  logic [3:0] result_map2;
  logic [2:0] fail_count2;

  int z_mode;
  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    int         accept;
    int         lat;
    logic       pass;
    logic [7:0] rmap;
    logic [3:0] fc;
    logic [2:0] xv;
  } exp_t;

  exp_t sb[$];
  exp_t sb2[$];

  and_tt_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .z(z), .x(x), .busy(busy), .done(done),
    .pass(pass), .result_map(result_map), .fail_count(fail_count)
  );

  and_tt_sequencer #(.N_IN(2), .SETTLE_CYCLES(1)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .z(z2), .x(x2), .busy(busy2), .done(done2),
    .pass(pass2), .result_map(result_map2), .fail_count(fail_count2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // AND port under test: 0 = correct, 1 = stuck at 0, 2 = stuck at 1
  assign z = (z_mode == 0) ? (&x) : (z_mode == 1) ? 1'b0 : 1'b1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("done_latency", 32'(cyc - e.accept), 32'(e.lat));
        checkOutput("pass",         32'(pass),           32'(e.pass));
        checkOutput("result_map",   32'(result_map),     32'(e.rmap));
        checkOutput("fail_count",   32'(fail_count),     32'(e.fc));
        checkOutput("x_at_done",    32'(x),              32'(e.xv));
        checkOutput("busy_at_done", 32'(busy),           32'd1);
      end
    end
  end

  always @(negedge clk) begin
    if (done2) begin
      if (sb2.size() == 0) begin
        checkOutput("unexpected_done2", 32'(done2), 32'd0);
      end else begin
        exp_t e;
        e = sb2.pop_front();
        checkOutput("done2_latency", 32'(cyc - e.accept), 32'(e.lat));
        checkOutput("pass2",         32'(pass2),          32'(e.pass));
        checkOutput("result_map2",   32'(result_map2),    32'(e.rmap));
        checkOutput("fail_count2",   32'(fail_count2),    32'(e.fc));
        checkOutput("x2_at_done",    32'(x2),             32'(e.xv));
      end
    end
  end

  task automatic applyStimulus(input int mode, input exp_t e);
    @(negedge clk);
    z_mode   = mode;
    start    = 1'b1;
    e.accept = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone();
    for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      checkOutput("done_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  function automatic exp_t mkExp(int lat, logic p, logic [7:0] rm, logic [3:0] fc, logic [2:0] xv);
    exp_t e;
    e.accept = 0;
    e.lat    = lat;
    e.pass   = p;
    e.rmap   = rm;
    e.fc     = fc;
    e.xv     = xv;
    return e;
  endfunction

  initial begin
    int acc;
    exp_t e2;
    rst    = 1'b1;
    start  = 1'b0;
    start2 = 1'b0;
    z_mode = 0;
    z2     = 1'b0;
    repeat (2) @(negedge clk);

    checkOutput("rst_x",          32'(x),          32'd0);
    checkOutput("rst_busy",       32'(busy),       32'd0);
    checkOutput("rst_done",       32'(done),       32'd0);
    checkOutput("rst_pass",       32'(pass),       32'd0);
    checkOutput("rst_result_map", 32'(result_map), 32'd0);
    checkOutput("rst_fail_count", 32'(fail_count), 32'd0);
    checkOutput("rst_busy2",      32'(busy2),      32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] scenario 1: correct AND port");
    applyStimulus(0, mkExp(40, 1'b1, 8'h80, 4'd0, 3'b111));
    checkOutput("busy_mid_sweep", 32'(busy), 32'd1);
    waitDone();
    repeat (3) @(negedge clk);
    checkOutput("busy_after_done", 32'(busy), 32'd0);
    checkOutput("x_hold_after",    32'(x),    32'd7);
    checkOutput("pass_held",       32'(pass), 32'd1);

    $display("[TB] scenario 2: z stuck at 0");
    applyStimulus(1, mkExp(40, 1'b0, 8'h00, 4'd1, 3'b111));
    waitDone();
    repeat (2) @(negedge clk);

    $display("[TB] scenario 3: z stuck at 1");
`ifdef AND_TT_STOP_ON_FAIL_EN
    applyStimulus(2, mkExp(5, 1'b0, 8'h01, 4'd1, 3'b000));
`else
    applyStimulus(2, mkExp(40, 1'b0, 8'hFF, 4'd7, 3'b111));
`endif
    waitDone();
    repeat (2) @(negedge clk);

    $display("[TB] scenario 4: reset mid-sweep");
    z_mode = 0;
    start  = 1'b1;
    acc    = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    repeat (17) @(negedge clk);
    checkOutput("x_before_abort", 32'(x), 32'd3);
    rst = 1'b1;
    #1;
    checkOutput("abort_x",          32'(x),          32'd0);
    checkOutput("abort_busy",       32'(busy),       32'd0);
    checkOutput("abort_pass",       32'(pass),       32'd0);
    checkOutput("abort_result_map", 32'(result_map), 32'd0);
    checkOutput("abort_fail_count", 32'(fail_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    checkOutput("abort_no_restart", 32'(busy), 32'd0);
    applyStimulus(0, mkExp(40, 1'b1, 8'h80, 4'd0, 3'b111));
    waitDone();
    repeat (2) @(negedge clk);

    $display("[TB] scenario 5: start while busy");
    applyStimulus(0, mkExp(40, 1'b1, 8'h80, 4'd0, 3'b111));
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (16) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone();
    repeat (10) @(negedge clk);
    checkOutput("no_queued_sweep", 32'(busy), 32'd0);

    $display("[TB] scenario 6: N_IN=2 SETTLE_CYCLES=1 with z toggling in SETTLE");
    e2 = mkExp(8, 1'b1, 8'h08, 4'd0, 3'b011);
    start2    = 1'b1;
    e2.accept = cyc + 1;
    sb2.push_back(e2);
    @(negedge clk);
    start2 = 1'b0;
    for (int r = 0; r < 9; r++) begin
      z2 = (r % 2 == 1) ? (&x2) : ~(&x2);
      @(negedge clk);
    end
    for (int i = 0; i < 20 && sb2.size() > 0; i++) @(negedge clk);
    if (sb2.size() > 0) begin
      checkOutput("done2_timeout", 32'(sb2.size()), 32'd0);
      sb2.delete();
    end
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
